// File: rtl/segre_csr_unit.sv
// segre_csr_unit: Zicsr execute-stage sequencer (read CSR, compute, optional write, respond).
// Optional build macro SEGRE_CSR_FAST_READ_EN folds the CSR read into the accept cycle.
module segre_csr_unit #(
  parameter int CSR_ADDR_W = 12,
  parameter int DATA_W     = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [2:0]            op_i,
  input  logic [CSR_ADDR_W-1:0] csr_addr_i,
  input  logic [4:0]            rs1_idx_i,
  input  logic [DATA_W-1:0]     rs1_data_i,
  input  logic [4:0]            rd_i,
  input  logic [1:0]            priv_i,
  input  logic                  flush_i,
  output logic [CSR_ADDR_W-1:0] csr_raddr_o,
  input  logic [DATA_W-1:0]     csr_data_i,
  output logic                  csr_we_o,
  output logic [CSR_ADDR_W-1:0] csr_waddr_o,
  output logic [DATA_W-1:0]     csr_data_o,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_W-1:0]     rsp_data_o,
  output logic [4:0]            rsp_rd_o,
  output logic                  rsp_illegal_o
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  logic [1:0]            r_state;
  logic [CSR_ADDR_W-1:0] r_addr;
  logic [4:0]            r_rd;
  logic [DATA_W-1:0]     r_old;
  logic [DATA_W-1:0]     r_new;
  logic                  r_illegal;

  logic                  w_accept;
  logic [DATA_W-1:0]     w_in_operand;
  logic [2:0]            w_ev_op;
  logic [CSR_ADDR_W-1:0] w_ev_addr;
  logic [4:0]            w_ev_idx;
  logic [DATA_W-1:0]     w_ev_operand;
  logic                  w_write_intent;
  logic                  w_illegal;
  logic [DATA_W-1:0]     w_new;
  logic                  w_goto_write;

  // A handshake that coincides with a flush is simply never taken.
  assign w_accept     = req_valid_i & req_ready_o & ~flush_i;
  assign w_in_operand = op_i[2] ? {{(DATA_W-5){1'b0}}, rs1_idx_i} : rs1_data_i;

`ifdef SEGRE_CSR_FAST_READ_EN
  assign w_ev_op      = op_i;
  assign w_ev_addr    = csr_addr_i;
  assign w_ev_idx     = rs1_idx_i;
  assign w_ev_operand = w_in_operand;
`else
  logic [2:0]        r_op;
  logic [4:0]        r_rs1_idx;
  logic [DATA_W-1:0] r_operand;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_op      <= '0;
      r_rs1_idx <= '0;
      r_operand <= '0;
    end else if (w_accept) begin
      r_op      <= op_i;
      r_rs1_idx <= rs1_idx_i;
      r_operand <= w_in_operand;
    end
  end

  assign w_ev_op      = r_op;
  assign w_ev_addr    = r_addr;
  assign w_ev_idx     = r_rs1_idx;
  assign w_ev_operand = r_operand;
`endif

  // Set/clear forms with rs1/zimm == 0 are pure reads and may target read-only CSRs.
  assign w_write_intent = (w_ev_op[1:0] == 2'b01) | (w_ev_idx != 5'd0);
  assign w_illegal      = (w_ev_op[1:0] == 2'b00)
                        | (priv_i < w_ev_addr[9:8])
                        | ((w_ev_addr[11:10] == 2'b11) & w_write_intent);
  assign w_goto_write   = ~w_illegal & w_write_intent;

  always_comb begin
    w_new = w_ev_operand;
    case (w_ev_op[1:0])
      2'b10:   w_new = csr_data_i | w_ev_operand;
      2'b11:   w_new = csr_data_i & ~w_ev_operand;
      default: w_new = w_ev_operand;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= ST_IDLE;
      r_addr    <= '0;
      r_rd      <= '0;
      r_old     <= '0;
      r_new     <= '0;
      r_illegal <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_addr <= csr_addr_i;
            r_rd   <= rd_i;
`ifdef SEGRE_CSR_FAST_READ_EN
            r_old     <= w_illegal ? '0 : csr_data_i;
            r_new     <= w_new;
            r_illegal <= w_illegal;
            r_state   <= w_goto_write ? ST_WRITE : ST_RESP;
`else
            r_state <= ST_READ;
`endif
          end
        end
        ST_READ: begin
          if (flush_i) begin
            r_state <= ST_IDLE;
          end else begin
            r_old     <= w_illegal ? '0 : csr_data_i;
            r_new     <= w_new;
            r_illegal <= w_illegal;
            r_state   <= w_goto_write ? ST_WRITE : ST_RESP;
          end
        end
        ST_WRITE: r_state <= ST_RESP;
        ST_RESP: begin
          if (rsp_ready_i) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Outputs are masked by rst_i so a reset landing mid-operation kills them in that same cycle.
  assign req_ready_o = (r_state == ST_IDLE) & ~rst_i;
  assign csr_we_o    = (r_state == ST_WRITE) & ~rst_i;
  assign rsp_valid_o = (r_state == ST_RESP) & ~rst_i;

`ifdef SEGRE_CSR_FAST_READ_EN
  assign csr_raddr_o = (req_ready_o & req_valid_i) ? csr_addr_i : '0;
`else
  assign csr_raddr_o = ((r_state == ST_READ) & ~rst_i) ? r_addr : '0;
`endif

  assign csr_waddr_o   = csr_we_o ? r_addr : '0;
  assign csr_data_o    = csr_we_o ? r_new : '0;
  assign rsp_data_o    = rsp_valid_o ? r_old : '0;
  assign rsp_rd_o      = rsp_valid_o ? r_rd : '0;
  assign rsp_illegal_o = rsp_valid_o & r_illegal;

endmodule

// File: tb/tb_segre_csr_unit.sv
// tb_segre_csr_unit: randomized scoreboard bench for segre_csr_unit with a behavioural CSR file.
module tb_segre_csr_unit;
  localparam int AW = 12;
  localparam int DW = 32;
`ifdef SEGRE_CSR_FAST_READ_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif
  localparam int WR_LAT = FAST ? 1 : 2;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          req_valid_i;
  logic          req_ready_o;
  logic [2:0]    op_i;
  logic [AW-1:0] csr_addr_i;
  logic [4:0]    rs1_idx_i;
  logic [DW-1:0] rs1_data_i;
  logic [4:0]    rd_i;
  logic [1:0]    priv_i;
  logic          flush_i;
  logic [AW-1:0] csr_raddr_o;
  logic [DW-1:0] csr_data_i;
  logic          csr_we_o;
  logic [AW-1:0] csr_waddr_o;
  logic [DW-1:0] csr_data_o;
  logic          rsp_valid_o;
  logic          rsp_ready_i;
  logic [DW-1:0] rsp_data_o;
  logic [4:0]    rsp_rd_o;
  logic          rsp_illegal_o;

  segre_csr_unit #(.CSR_ADDR_W(AW), .DATA_W(DW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .op_i(op_i), .csr_addr_i(csr_addr_i), .rs1_idx_i(rs1_idx_i), .rs1_data_i(rs1_data_i),
    .rd_i(rd_i), .priv_i(priv_i), .flush_i(flush_i), .csr_raddr_o(csr_raddr_o),
    .csr_data_i(csr_data_i), .csr_we_o(csr_we_o), .csr_waddr_o(csr_waddr_o),
    .csr_data_o(csr_data_o), .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_data_o(rsp_data_o), .rsp_rd_o(rsp_rd_o), .rsp_illegal_o(rsp_illegal_o)
  );

  always #5 clk_i = ~clk_i;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int rsp_done = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct { logic [11:0] addr; logic [31:0] data; int cyc; } wr_t;
  typedef struct { logic [31:0] data; logic [4:0] rd; logic illegal; int cyc; } rsp_t;
  wr_t  wq[$];
  rsp_t rq[$];

  function automatic logic [31:0] init_val(input logic [11:0] a);
    return {a[7:0], ~a, a};
  endfunction

  // CSR file seen by the DUT: untouched entries read their power-on pattern.
  logic [31:0] csr_mem [4096];
  bit          csr_wr  [4096];
  always @(posedge clk_i) begin
    if (csr_we_o) begin
      csr_mem[csr_waddr_o] <= csr_data_o;
      csr_wr[csr_waddr_o]  <= 1'b1;
    end
  end
  assign csr_data_i = csr_wr[csr_raddr_o] ? csr_mem[csr_raddr_o] : init_val(csr_raddr_o);

  // Reference architectural CSR state.
  logic [31:0] ref_csr [4096];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  task automatic model(input logic [2:0] op, input logic [11:0] addr, input logic [4:0] idx,
                       input logic [31:0] d, input logic [4:0] rd, input logic [1:0] priv,
                       input int hs);
    logic [1:0]  kind;
    logic [31:0] operand, old, nv;
    bit          writes, illegal;
    wr_t         w;
    rsp_t        r;
    kind    = op[1:0];
    operand = op[2] ? 32'(idx) : d;
    writes  = (kind == 2'd1) || (idx != 5'd0);
    illegal = (kind == 2'd0) || (priv < addr[9:8]) || (addr[11:10] == 2'b11 && writes);
    old     = ref_csr[addr];
    case (kind)
      2'd1:    nv = operand;
      2'd2:    nv = old | operand;
      default: nv = old & ~operand;
    endcase
    if (!illegal && writes) begin
      w.addr = addr; w.data = nv; w.cyc = hs + WR_LAT;
      wq.push_back(w);
      ref_csr[addr] = nv;
    end
    r.data    = illegal ? 32'd0 : old;
    r.rd      = rd;
    r.illegal = illegal;
    r.cyc     = hs + WR_LAT + ((!illegal && writes) ? 1 : 0);
    rq.push_back(r);
  endtask

  // Monitor: pops expectations whenever the DUT writes or presents a response.
  bit   held = 0;
  rsp_t held_v;
  always @(negedge clk_i) begin
    wr_t  w;
    rsp_t r;
    if (csr_we_o) begin
      if (wq.size() == 0) flag("unexpected_write");
      else begin
        w = wq.pop_front();
        check("write_addr", 32'(csr_waddr_o), 32'(w.addr));
        check("write_data", csr_data_o, w.data);
        check("write_cycle", 32'(cyc), 32'(w.cyc));
      end
    end
    if (rsp_valid_o) begin
      check("rsp_req_ready_low", 32'(req_ready_o), 32'd0);
      if (!held) begin
        if (rq.size() == 0) flag("unexpected_rsp");
        else begin
          r = rq.pop_front();
          check("rsp_data", rsp_data_o, r.data);
          check("rsp_rd", 32'(rsp_rd_o), 32'(r.rd));
          check("rsp_illegal", 32'(rsp_illegal_o), 32'(r.illegal));
          check("rsp_cycle", 32'(cyc), 32'(r.cyc));
        end
      end else begin
        check("rsp_hold_data", rsp_data_o, held_v.data);
        check("rsp_hold_rd", 32'(rsp_rd_o), 32'(held_v.rd));
        check("rsp_hold_illegal", 32'(rsp_illegal_o), 32'(held_v.illegal));
      end
      held           = !rsp_ready_i;
      held_v.data    = rsp_data_o;
      held_v.rd      = rsp_rd_o;
      held_v.illegal = rsp_illegal_o;
      if (rsp_ready_i) rsp_done++;
    end else begin
      if (held) flag("rsp_dropped_before_accept");
      held = 0;
    end
  end

  // fk: 0 normal, 1 flush with handshake, 2 flush in READ, 3 flush in WRITE/RESP, 4 reset in WRITE.
  task automatic run_op(input logic [2:0] op, input logic [11:0] addr, input logic [4:0] idx,
                        input logic [31:0] d, input logic [4:0] rd, input logic [1:0] priv,
                        input int fk, input int hold);
    int hs, n, start;
    bit dropped;
    dropped = (fk == 1) || (fk == 2 && !FAST);
    start   = rsp_done;
    @(posedge clk_i); #1;
    req_valid_i = 1'b1; op_i = op; csr_addr_i = addr; rs1_idx_i = idx;
    rs1_data_i = d; rd_i = rd; priv_i = priv;
    flush_i = (fk == 1); rsp_ready_i = (hold == 0);
    n = 0;
    @(negedge clk_i);
    while (!req_ready_o && n < 20) begin @(negedge clk_i); n++; end
    if (!req_ready_o) begin
      flag("req_ready_timeout");
      req_valid_i = 1'b0; flush_i = 1'b0; rsp_ready_i = 1'b1;
      return;
    end
    hs = cyc;
    if (!dropped && fk != 4) model(op, addr, idx, d, rd, priv, hs);
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    flush_i = (fk == 2);
    if (dropped) begin
      if (fk == 2) begin @(posedge clk_i); #1; flush_i = 1'b0; end
      @(negedge clk_i);
      check("req_ready_after_flush", 32'(req_ready_o), 32'd1);
      repeat (4) @(posedge clk_i);
      #1;
      return;
    end
    if (fk == 4) begin
      if (!FAST) begin @(posedge clk_i); #1; end
      rst_i = 1'b1;
      @(negedge clk_i);
      check("we_in_reset_cycle", 32'(csr_we_o), 32'd0);
      check("rsp_valid_in_reset", 32'(rsp_valid_o), 32'd0);
      repeat (2) @(posedge clk_i);
      #1; rst_i = 1'b0;
      repeat (4) @(posedge clk_i);
      #1;
      return;
    end
    if (fk == 3) begin @(posedge clk_i); #1; flush_i = 1'b1; end
    if (hold > 0) begin
      n = 0;
      while (!rsp_valid_o && n < 20) begin @(negedge clk_i); n++; end
      if (!rsp_valid_o) flag("rsp_valid_timeout");
      repeat (hold) @(negedge clk_i);
      @(posedge clk_i); #1;
      rsp_ready_i = 1'b1;
    end
    n = 0;
    while (rsp_done == start && n < 50) begin @(posedge clk_i); n++; end
    if (rsp_done == start) flag("rsp_accept_timeout");
    #1;
    flush_i = 1'b0;
    rsp_ready_i = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  r_op;
    logic [11:0] r_addr;
    logic [4:0]  r_idx;
    int          r_fk, r_hold, sel;
    for (int i = 0; i < 4096; i++) ref_csr[i] = init_val(12'(i));
    rst_i = 1'b1; req_valid_i = 1'b0; op_i = '0; csr_addr_i = '0; rs1_idx_i = '0;
    rs1_data_i = '0; rd_i = '0; priv_i = '0; flush_i = 1'b0; rsp_ready_i = 1'b1;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check("reset_req_ready", 32'(req_ready_o), 32'd0);
    check("reset_rsp_valid", 32'(rsp_valid_o), 32'd0);
    check("reset_csr_we", 32'(csr_we_o), 32'd0);
    check("reset_raddr", 32'(csr_raddr_o), 32'd0);
    check("reset_waddr", 32'(csr_waddr_o), 32'd0);
    check("reset_wdata", csr_data_o, 32'd0);
    check("reset_rsp_data", rsp_data_o, 32'd0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    check("idle_req_ready", 32'(req_ready_o), 32'd1);
    check("idle_rsp_valid", 32'(rsp_valid_o), 32'd0);

    run_op(3'b001, 12'h105, 5'd9, 32'h0000_2000, 5'd1, 2'd3, 0, 0);
    run_op(3'b010, 12'h105, 5'd3, 32'h0000_00F0, 5'd5, 2'd1, 0, 0);
    run_op(3'b111, 12'h100, 5'd0, 32'hFFFF_FFFF, 5'd6, 2'd1, 0, 0);
    run_op(3'b001, 12'h180, 5'd4, 32'h1234_5678, 5'd7, 2'd0, 0, 0);
    run_op(3'b001, 12'h180, 5'd4, 32'h1234_5678, 5'd7, 2'd1, 0, 0);
    run_op(3'b001, 12'hC00, 5'd4, 32'hDEAD_BEEF, 5'd8, 2'd3, 0, 0);
    run_op(3'b010, 12'hC00, 5'd0, 32'hDEAD_BEEF, 5'd8, 2'd3, 0, 0);
    run_op(3'b011, 12'h105, 5'd2, 32'h0000_00F0, 5'd9, 2'd3, 0, 5);
    run_op(3'b001, 12'h105, 5'd2, 32'hAAAA_5555, 5'd10, 2'd3, 2, 0);
    run_op(3'b001, 12'h105, 5'd2, 32'hAAAA_5555, 5'd10, 2'd3, 1, 0);
    run_op(3'b000, 12'h105, 5'd2, 32'h1111_1111, 5'd11, 2'd3, 0, 0);
    run_op(3'b100, 12'h105, 5'd2, 32'h1111_1111, 5'd11, 2'd3, 0, 0);
    run_op(3'b101, 12'h340, 5'd17, 32'hFFFF_FFFF, 5'd12, 2'd3, 3, 0);
    run_op(3'b110, 12'h340, 5'd8, 32'h0, 5'd13, 2'd3, 0, 2);

    for (int t = 0; t < 200; t++) begin
      r_op   = 3'($urandom);
      r_addr = {2'($urandom), 2'($urandom), 8'($urandom_range(0, 3))};
      r_idx  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      sel    = $urandom_range(0, 9);
      r_fk   = (sel < 3) ? sel + 1 : 0;
      r_hold = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 4) : 0;
      run_op(r_op, r_addr, r_idx, $urandom, 5'($urandom), 2'($urandom), r_fk, r_hold);
    end

    run_op(3'b001, 12'h105, 5'd1, 32'h5555_0000, 5'd14, 2'd3, 4, 0);
    run_op(3'b010, 12'h105, 5'd0, 32'h0, 5'd15, 2'd3, 0, 0);

    repeat (4) @(posedge clk_i);
    check("write_queue_drained", 32'(wq.size()), 32'd0);
    check("rsp_queue_drained", 32'(rq.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
